// File: rtl/clock_speed_ctrl_if.sv
// Direct-load handshake between the config logic and clock_speed_ctrl.
// The requester drives valid/value; the controller answers with ready.
interface clock_speed_ctrl_if;
    logic        load_valid;
    logic [31:0] load_value;
    logic        load_ready;

    modport master (
        output load_valid,
        output load_value,
        input  load_ready
    );

    modport slave (
        input  load_valid,
        input  load_value,
        output load_ready
    );
endinterface

// File: rtl/clock_speed_ctrl.sv
// Serial configuration loader for the clock divider: direct loads,
// halve/double speed steps, and an automatic default load after reset.
module clock_speed_ctrl #(
    parameter logic [31:0] RESET_DIVISOR = 32'd5_999_999,
    parameter logic [31:0] MIN_DIVISOR   = 32'd1,
    parameter logic [31:0] MAX_DIVISOR   = 32'hFFFF_FFFF,
    parameter int unsigned SETUP_CYCLES  = 1,
    parameter int unsigned GAP_CYCLES    = 2
) (
    input  logic               fastClk,
    input  logic               rst,
    clock_speed_ctrl_if.slave  lif,
    input  logic               speed_up,
    input  logic               speed_down,
    output logic               clock_change_mode,
    output logic               clock_max_count,
    output logic               busy,
    output logic [31:0]        cur_divisor
);

    typedef enum logic [2:0] {
        START,
        IDLE,
        ARM,
        SHIFT,
        GAP
    } state_t;

    localparam logic [1:0] P_NONE = 2'b00;
    localparam logic [1:0] P_UP   = 2'b01;
    localparam logic [1:0] P_DN   = 2'b10;

    state_t      state, state_d;
    logic [31:0] cnt, cnt_d;
    logic [31:0] sreg;
    logic [1:0]  pend;
    logic        ready_q;
    logic        ready_d;
    logic        take_load;
    logic        take_step;
    logic [31:0] half_d;
    logic [32:0] dbl_d;
    logic [31:0] up_val;
    logic [31:0] dn_val;
    logic [31:0] step_val;

    assign lif.load_ready = ready_q;

    // Steps are computed from the committed divisor at dispatch time.
    assign half_d   = cur_divisor >> 1;
    assign dbl_d    = {cur_divisor, 1'b1};
    assign up_val   = (half_d < MIN_DIVISOR) ? MIN_DIVISOR : half_d;
    assign dn_val   = (cur_divisor[31] || (dbl_d > {1'b0, MAX_DIVISOR}))
                    ? MAX_DIVISOR : dbl_d[31:0];
    assign step_val = (pend == P_UP) ? up_val : dn_val;

    always_comb begin
        state_d   = state;
        cnt_d     = cnt;
        take_load = 1'b0;
        take_step = 1'b0;
        unique case (state)
            START: begin
                state_d = ARM;
                cnt_d   = '0;
            end
            IDLE: begin
                if (ready_q) begin
                    if (lif.load_valid) begin
                        take_load = 1'b1;
                    end else if (pend != P_NONE) begin
                        take_step = 1'b1;
                    end
                end
                if (take_load || take_step) begin
                    state_d = ARM;
                    cnt_d   = '0;
                end
            end
            ARM: begin
                if (cnt == SETUP_CYCLES - 1) begin
                    state_d = SHIFT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt + 32'd1;
                end
            end
            SHIFT: begin
                if (cnt == 32'd31) begin
                    state_d = GAP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt + 32'd1;
                end
            end
            GAP: begin
                if (cnt == GAP_CYCLES - 1) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt + 32'd1;
                end
            end
            default: begin
                state_d = START;
                cnt_d   = '0;
            end
        endcase
        ready_d = (state == IDLE) && !(take_load || take_step);
    end

    always_ff @(posedge fastClk or negedge rst) begin
        if (!rst) begin
            state             <= START;
            cnt               <= '0;
            sreg              <= RESET_DIVISOR;
            cur_divisor       <= RESET_DIVISOR;
            pend              <= P_NONE;
            ready_q           <= 1'b0;
            busy              <= 1'b1;
            clock_change_mode <= 1'b0;
            clock_max_count   <= 1'b0;
        end else begin
            state   <= state_d;
            cnt     <= cnt_d;
            ready_q <= ready_d;
            busy    <= !ready_d;
            if (take_load) begin
                sreg <= lif.load_value;
            end else if (take_step) begin
                sreg <= step_val;
            end
            if (state == ARM && cnt == 32'd0) begin
                cur_divisor <= sreg;
            end
            clock_change_mode <= (state == ARM) || (state == SHIFT);
            clock_max_count   <= (state == SHIFT) && sreg[cnt[4:0]];
            // Newest pulse wins; a simultaneous up+down cancels the slot.
            if (speed_up && speed_down) begin
                pend <= P_NONE;
            end else if (speed_up) begin
                pend <= P_UP;
            end else if (speed_down) begin
                pend <= P_DN;
            end else if (take_step) begin
                pend <= P_NONE;
            end
        end
    end

endmodule

// File: doc/clock_speed_ctrl.md
# clock_speed_ctrl

Configuration controller for the clock divider. It owns the divider's serial configuration port (`clock_change_mode` / `clock_max_count`) and loads 32-bit divisor values into it. The values come from two requesters: a direct parallel load (valid/ready) and single-cycle speed-step pulses that halve or double the current divisor. It sits between the front-panel/config logic and the divider, and performs an automatic load of a default divisor after every reset.

## Interface
- `RESET_DIVISOR`, 32'd5_999_999, divisor loaded automatically after reset (1 Hz slowClk from 12 MHz).
- `MIN_DIVISOR`, 32'd1, lower saturation bound for speed_up.
- `MAX_DIVISOR`, 32'hFFFF_FFFF, upper saturation bound for speed_down.
- `SETUP_CYCLES`, 1, cycles of mode-high before bit 0 is driven (≥1).
- `GAP_CYCLES`, 2, minimum mode-low cycles after a load before the next (≥2).
- `fastClk`  input  1  system clock (12 MHz); the only clock.
- `rst`  input  1  asynchronous, active-low reset.
- `load_valid`  input  1  direct-load request.
- `load_value`  input  32  divisor for the direct load; sampled on handshake.
- `load_ready`  output  1  high only in IDLE.
- `speed_up`  input  1  single-cycle pulse: halve the divisor.
- `speed_down`  input  1  single-cycle pulse: double the divisor.
- `clock_change_mode`  output  1  to divider; high for the whole load window.
- `clock_max_count`  output  1  to divider; serial divisor bit, LSB first.
- `busy`  output  1  high in any state other than IDLE.
- `cur_divisor`  output  32  divisor most recently committed to a load.

## Operation
- FSM states: START, IDLE, ARM, SHIFT, GAP.
- Reset (async, `rst`=0): state=START, shift register=RESET_DIVISOR, `cur_divisor`=RESET_DIVISOR, `clock_change_mode`=0, `clock_max_count`=0, `load_ready`=0, `busy`=1, pending step cleared.
- START → ARM unconditionally on the first clock edge after release. This reprograms the divider, whose divisor resets to 0.
- IDLE selects the next load in this priority order:
  1. `load_valid` (handshake). `cur_divisor` and the shift register take `load_value`.
  2. A pending step. up: d' = max(d>>1, MIN_DIVISOR). down: d' = (d[31] ? MAX_DIVISOR : min((d<<1)|1, MAX_DIVISOR)). d' commits to `cur_divisor`.
  3. Otherwise stay in IDLE.
- ARM lasts SETUP_CYCLES cycles with mode=1 and serial=0. The divider's counter resets on the mode edge.
- SHIFT lasts exactly 32 cycles. Cycle k drives bit k of the shift register; mode=1.
- GAP lasts GAP_CYCLES cycles with mode=0 and serial=0, then the FSM returns to IDLE.
- Mode must be high for exactly SETUP_CYCLES+32 cycles. An extra cycle would wrap the divider's 5-bit index and corrupt bit 0.
- Step capture works in any state, including reset release:
  - A `speed_up`/`speed_down` pulse writes a 2-bit pending slot (up/down/none). The newest pulse wins.
  - up and down in the same cycle clear the slot.
  - Steps are computed from `cur_divisor` at dispatch time, not at capture time.
  - Only one step is retained; further pulses overwrite it.
- If a direct load and a pending step meet in IDLE, the load is taken and the step stays pending. It is dispatched after the following GAP.
- Reset mid-load: outputs return to their reset values asynchronously, and the START auto-load follows release.

## Timing
- All outputs are registered.
- Handshake: accept at edge N (`load_valid`&`load_ready`). Edge N+1: mode=1, `busy`=1, `load_ready`=0, `cur_divisor`=new.
- Mode high at edge T. Bit k is valid from edge T+SETUP_CYCLES+k, for k=0..31. Mode falls at edge T+SETUP_CYCLES+32.
- `load_ready` returns at edge T+SETUP_CYCLES+32+GAP_CYCLES (defaults: T+35).
- Load-to-load minimum period: 1+SETUP_CYCLES+32+GAP_CYCLES cycles (defaults: 36).
- A pending step dispatches from IDLE with the same 1-cycle latency as a load.
- The divider's slowClk is held low while mode=1. This is expected and not masked.

## Test plan
- Reset release with defaults:
  - Mode high at edge 1, for cycles 1–33.
  - Serial stream in cycles 2–33 equals 0x005B8D7F LSB-first.
  - `load_ready` at edge 36.
  - `cur_divisor`=5_999_999 from reset onward.
- Direct load 0xA5A5_0F01 in IDLE:
  - Accepted; bits stream LSB-first 1,0,0,0,0,0,0,0,1,1,1,1,0,0,0,0,…
  - Mode high for exactly 33 cycles; the divider's maxCount reads 0xA5A5_0F01 afterward.
- Steps:
  - `speed_up` ×3 from divisor 6, spaced 40 cycles apart: committed divisors 3, 1, 1 (MIN saturation).
  - `speed_down` at 0x8000_0000: committed divisor 0xFFFF_FFFF.
- Priority and collisions:
  - `load_valid`(0x10) and a `speed_up` pulse in the same IDLE cycle: load 0x10 first, then an automatic second load of 0x8.
  - Simultaneous up+down: no load occurs.
- Reset mid-operation:
  - Assert `rst` at SHIFT bit 12 of a load of 0xFFFF_FFFF: mode=0 and serial=0 immediately.
  - After release, a full RESET_DIVISOR load follows with the START timing.
- Pulses during busy:
  - `speed_down`, then `speed_up`, both during SHIFT: only one load (up) follows GAP.
  - `load_ready` stays 0 throughout busy.
